// File: rtl/mem_access_unit.sv
// Load/store sequencer for the byte-addressed data RAM: validates each request,
// walks the RAM through SETUP/STROBE/CAPTURE and returns a one-cycle response.
module mem_access_unit #(
  parameter int dataWidth = 32,
  parameter int memBytes  = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [1:0]           reqSize,
  input  logic                 reqSigned,
  input  logic [dataWidth-1:0] reqAddress,
  input  logic [dataWidth-1:0] reqWriteData,
  output logic                 respValid,
  output logic [dataWidth-1:0] respData,
  output logic                 respError,
  output logic                 memWrite,
  output logic                 memRead,
  output logic [1:0]           sizeSignal,
  output logic [dataWidth-1:0] address,
  output logic [dataWidth-1:0] writeData,
  input  logic [dataWidth-1:0] readData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE,
    S_RESP
  } state_t;

  localparam logic [dataWidth:0] MEM_LIMIT = (dataWidth + 1)'(memBytes);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_write;
  logic                 r_signed;
  logic [1:0]           r_size;
  logic [dataWidth-1:0] r_address;
  logic [dataWidth-1:0] r_write_data;
  logic [dataWidth-1:0] r_resp_data;
  logic                 r_resp_error;

  logic                 w_accept;
  logic                 w_illegal;
  logic [1:0]           w_bytes_m1;
  logic [dataWidth:0]   w_last;
  logic [dataWidth-1:0] w_word_rev;
  logic [dataWidth-1:0] w_load_data;

  assign w_accept = (r_state == S_IDLE) && reqValid;

  always_comb begin
    w_bytes_m1 = 2'd0;
    case (reqSize)
      2'd1:    w_bytes_m1 = 2'd1;
      2'd2:    w_bytes_m1 = 2'd3;
      default: w_bytes_m1 = 2'd0;
    endcase
  end

  // Last touched byte, one bit wider than the address so a carry cannot wrap.
  assign w_last    = {1'b0, reqAddress} + {{(dataWidth - 1){1'b0}}, w_bytes_m1};
  assign w_illegal = (reqSize == 2'd3)
                   || ((reqSize == 2'd1) && reqAddress[0])
                   || ((reqSize == 2'd2) && (reqAddress[1:0] != 2'b00))
                   || (w_last >= MEM_LIMIT);

  // The RAM presents the byte at the lowest address in the most significant lane.
  genvar gi;
  generate
    for (gi = 0; gi < dataWidth / 8; gi++) begin : g_rev
      assign w_word_rev[gi*8 +: 8] = readData[dataWidth-8-gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    w_load_data = w_word_rev;
    case (r_size)
      2'd0:    w_load_data = {{(dataWidth - 8){r_signed & readData[7]}}, readData[7:0]};
      2'd1:    w_load_data = {{(dataWidth - 16){r_signed & readData[7]}},
                              readData[7:0], readData[15:8]};
      default: w_load_data = w_word_rev;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    reqReady     = 1'b0;
    respValid    = 1'b0;
    memWrite     = 1'b0;
    memRead      = 1'b0;
    case (r_state)
      S_IDLE: begin
        reqReady = 1'b1;
        if (reqValid) w_state_next = w_illegal ? S_RESP : S_SETUP;
      end
      S_SETUP:   w_state_next = S_STROBE;
      S_STROBE: begin
        memWrite     = r_write;
        memRead      = !r_write;
        w_state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        memWrite     = r_write;
        memRead      = !r_write;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        respValid    = 1'b1;
        w_state_next = S_IDLE;
      end
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= 2'd0;
      r_address    <= '0;
      r_write_data <= '0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_write      <= reqWrite;
        r_signed     <= reqSigned;
        r_resp_error <= w_illegal;
        r_resp_data  <= '0;
        // Illegal requests leave the RAM-facing bus untouched.
        if (!w_illegal) begin
          r_size       <= reqSize;
          r_address    <= reqAddress;
          r_write_data <= reqWriteData;
        end
      end
      if ((r_state == S_CAPTURE) && !r_write) r_resp_data <= w_load_data;
    end
  end

  assign sizeSignal = r_size;
  assign address    = r_address;
  assign writeData  = r_write_data;
  assign respData   = r_resp_data;
  assign respError  = r_resp_error;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte RAM model and a response scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [31:0] reqAddress;
  logic [31:0] reqWriteData;
  logic        respValid;
  logic [31:0] respData;
  logic        respError;
  logic        memWrite;
  logic        memRead;
  logic [1:0]  sizeSignal;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;

  mem_access_unit #(.dataWidth(32), .memBytes(512)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddress(reqAddress),
    .reqWriteData(reqWriteData),
    .respValid(respValid), .respData(respData), .respError(respError),
    .memWrite(memWrite), .memRead(memRead), .sizeSignal(sizeSignal),
    .address(address), .writeData(writeData), .readData(readData)
  );

  always #5 clk = ~clk;

  // RAM model: stores little-endian, presents loads with the lowest address in the top lane.
  logic [7:0] mem [0:511];

  always @(posedge memWrite) begin
    logic [8:0] a;
    a = address[8:0];
    case (sizeSignal)
      2'd0: mem[a] = writeData[7:0];
      2'd1: begin mem[a] = writeData[7:0]; mem[a+9'd1] = writeData[15:8]; end
      default: begin
        mem[a]       = writeData[7:0];
        mem[a+9'd1]  = writeData[15:8];
        mem[a+9'd2]  = writeData[23:16];
        mem[a+9'd3]  = writeData[31:24];
      end
    endcase
  end

  always @(posedge memRead) begin
    logic [8:0] a;
    a = address[8:0];
    case (sizeSignal)
      2'd0:    readData = {24'hA5A5A5, mem[a]};
      2'd1:    readData = {16'hA5A5, mem[a], mem[a+9'd1]};
      default: readData = {mem[a], mem[a+9'd1], mem[a+9'd2], mem[a+9'd3]};
    endcase
  end

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int   n_pass   = 0;
  int   n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a negedge; drives one request and returns just after its accepting edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_data, input logic exp_err, input logic hold);
    exp_t e;
    int   n = 0;
    while (!reqReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady) chk("ready_wait", {31'd0, reqReady}, 32'd1);
    reqWrite     = wr;
    reqSize      = sz;
    reqSigned    = sg;
    reqAddress   = addr;
    reqWriteData = wd;
    reqValid     = 1'b1;
    e.data = exp_data;
    e.err  = exp_err;
    e.wr   = wr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) reqValid = 1'b0;
  endtask

  // Follows the response cycle by cycle after acceptance, then one cycle beyond it.
  task automatic collect(input string tag, input int exp_lat);
    logic [15:0] wm = '0;
    logic [15:0] rm = '0;
    logic [15:0] rdy = '0;
    logic        got = 1'b0;
    int          lat = 0;
    exp_t        e;
    logic [15:0] exp_wm;
    logic [15:0] exp_rm;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      wm[k]  = memWrite;
      rm[k]  = memRead;
      rdy[k] = reqReady;
      if (respValid) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    if (got) begin
      chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_data"}, respData, e.data);
        chk({tag, "_error"}, {31'd0, respError}, {31'd0, e.err});
        exp_wm = (!e.err && e.wr)  ? 16'h000C : 16'h0000;
        exp_rm = (!e.err && !e.wr) ? 16'h000C : 16'h0000;
        chk({tag, "_memWrite_cycles"}, {16'd0, wm}, {16'd0, exp_wm});
        chk({tag, "_memRead_cycles"}, {16'd0, rm}, {16'd0, exp_rm});
      end
      chk({tag, "_ready_low_while_busy"}, {16'd0, rdy}, 32'd0);
      $display("resp %s: data=0x%08h err=%0b latency=%0d", tag, respData, respError, lat);
    end
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"}, {31'd0, respValid}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, reqReady}, 32'd1);
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    readData     = 32'h0;
    reset        = 1'b1;
    reqValid     = 1'b0;
    reqWrite     = 1'b0;
    reqSize      = 2'd0;
    reqSigned    = 1'b0;
    reqAddress   = 32'h0;
    reqWriteData = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_reqReady", {31'd0, reqReady}, 32'd1);
    chk("rst_respValid", {31'd0, respValid}, 32'd0);
    chk("rst_respError", {31'd0, respError}, 32'd0);
    chk("rst_strobes", {30'd0, memWrite, memRead}, 32'd0);
    chk("rst_respData", respData, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_sizeSignal", {30'd0, sizeSignal}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    collect("st_word_10", 4);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    collect("ld_word_10", 4);

    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h00000080, 32'h0, 1'b0, 1'b0);
    collect("st_byte_21", 4);
    issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    collect("ld_sbyte_21", 4);
    issue(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 32'h00000080, 1'b0, 1'b0);
    collect("ld_ubyte_21", 4);

    issue(1'b1, 2'd1, 1'b0, 32'h40, 32'h00008001, 32'h0, 1'b0, 1'b0);
    collect("st_half_40", 4);
    issue(1'b0, 2'd1, 1'b1, 32'h40, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
    collect("ld_shalf_40", 4);
    issue(1'b0, 2'd0, 1'b0, 32'h41, 32'h0, 32'h00000080, 1'b0, 1'b0);
    collect("ld_ubyte_41", 4);

    issue(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0);
    collect("err_word_13", 1);
    issue(1'b0, 2'd1, 1'b0, 32'h05, 32'h0, 32'h0, 1'b1, 1'b0);
    collect("err_half_05", 1);
    issue(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1'b0);
    collect("err_size3_00", 1);
    issue(1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0, 32'h0, 1'b1, 1'b0);
    collect("err_word_1FE", 1);
    issue(1'b1, 2'd0, 1'b0, 32'h200, 32'h55, 32'h0, 1'b1, 1'b0);
    collect("err_stbyte_200", 1);
    issue(1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0, 32'h0, 1'b0, 1'b0);
    collect("ld_word_1FC", 4);

    // Two stores with reqValid held throughout.
    issue(1'b1, 2'd2, 1'b0, 32'h80, 32'h11223344, 32'h0, 1'b0, 1'b1);
    reqWrite     = 1'b1;
    reqSize      = 2'd1;
    reqSigned    = 1'b0;
    reqAddress   = 32'h84;
    reqWriteData = 32'h0000A5C3;
    sb.push_back('{data: 32'h0, err: 1'b0, wr: 1'b1});
    collect("b2b_first", 4);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    collect("b2b_second", 4);
    issue(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h11223344, 1'b0, 1'b0);
    collect("ld_word_80", 4);
    issue(1'b0, 2'd1, 1'b1, 32'h84, 32'h0, 32'hFFFFA5C3, 1'b0, 1'b0);
    collect("ld_shalf_84", 4);

    // Reset during STROBE of a load.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("rst_mid_memRead_before", {31'd0, memRead}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_memRead_async", {31'd0, memRead}, 32'd0);
    if (sb.size() != 0) void'(sb.pop_front());
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | respValid;
      if (k == 1) reset = 1'b0;
    end
    chk("rst_mid_no_resp", {31'd0, seen}, 32'd0);
    chk("rst_mid_ready", {31'd0, reqReady}, 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    collect("ld_after_reset", 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequencing front end for the byte-addressed data RAM. It accepts one load or store request at a time from the datapath and checks size, alignment and range. It then drives the RAM's `memWrite`/`memRead` strobes, `sizeSignal`, `address` and `writeData` through a fixed multi-cycle sequence. It reorders and sign- or zero-extends load data and returns a single-cycle response carrying data or an error flag.

## Interface
- `dataWidth`, 32, data and address width
- `memBytes`, 512, RAM size in bytes; any access touching an address ≥ `memBytes` is an error
- `clk` input 1 — sole clock, rising edge
- `reset` input 1 — asynchronous, active-high
- `reqValid` input 1 — request present
- `reqReady` output 1 — unit can accept a request; high only in IDLE
- `reqWrite` input 1 — 1 = store, 0 = load
- `reqSize` input 2 — 0 byte, 1 halfword, 2 word, 3 illegal
- `reqSigned` input 1 — loads: 1 sign-extend, 0 zero-extend; ignored for stores
- `reqAddress` input 32 — byte address
- `reqWriteData` input 32 — store data, little-endian (byte at `reqAddress` = bits 7:0)
- `respValid` output 1 — one-cycle response pulse
- `respData` output 32 — load result; 0 for stores and errors
- `respError` output 1 — misaligned, out-of-range or illegal-size request
- `memWrite`, `memRead` output 1 — RAM strobes
- `sizeSignal` output 2 — RAM size code
- `address` output 32 — RAM address
- `writeData` output 32 — RAM write data
- `readData` input 32 — RAM read data

## Operation
- States: IDLE, SETUP, STROBE, CAPTURE, RESP.
- IDLE: `reqReady`=1. When `reqValid`=1 at a rising edge, the unit latches all request fields.
  - Legal request: go to SETUP.
  - Illegal request: go to RESP with the error flag set. The RAM is never touched.
- Error conditions:
  - `reqSize`=3.
  - Halfword with `reqAddress[0]`=1.
  - Word with `reqAddress[1:0]`≠0.
  - `reqAddress` + bytes − 1 ≥ `memBytes`, computed in 33 bits so there is no wrap.
- SETUP: drive `address`, `sizeSignal` and `writeData` (= latched `reqWriteData`) with both strobes low. Go to STROBE.
- STROBE: assert `memWrite` (store) or `memRead` (load). The rising strobe triggers the RAM. Address, size and data stay stable. Go to CAPTURE.
- CAPTURE: the strobe stays high. For loads, register `readData` and reorder it:
  - byte: result = `readData[7:0]`
  - halfword: `readData[15:8]` is the byte at address and `readData[7:0]` is the byte at address+1; result = {`readData[7:0]`, `readData[15:8]`}
  - word: `readData[31:24]` is the byte at address, through `readData[7:0]` at address+3; result = byte-reversed `readData`
- Extension: extend the result to 32 bits from its top bit (bit 7 or bit 15) when `reqSigned`=1, else zero-fill. Go to RESP.
- RESP: both strobes low. `respValid`=1 for exactly one cycle, with `respData`/`respError` valid. Then go to IDLE.
- The response has no backpressure; the consumer must take it in the pulse cycle.
- `address`, `sizeSignal` and `writeData` hold their last values outside SETUP..CAPTURE. Strobes are high only in STROBE and CAPTURE.

## Timing
- Reset (async, immediate): state IDLE; `reqReady`=1; `respValid`, `respError`, `memWrite`, `memRead` = 0; `respData`, `address`, `writeData` = 0; `sizeSignal`=0.
- Legal request accepted at edge 0:
  - SETUP in cycle 1
  - strobe high in cycles 2–3
  - `respValid` in cycle 4
  - next request can be accepted at the edge ending cycle 5 (IDLE)
- Illegal request accepted at edge 0: `respValid`=1 with `respError`=1 in cycle 1. No strobe is ever asserted.
- `reqValid` while not in IDLE is ignored (`reqReady`=0). Requesters must hold the request until accepted.
- Reset mid-operation: strobes drop asynchronously and no response is issued. A store interrupted in STROBE/CAPTURE may have partially written; the unit makes no guarantee.
- Back-to-back legal requests: one per 5 cycles.

## Test plan
- Store word 0xDEADBEEF at 0x10, then unsigned word load at 0x10 -> load response `respData`=0xDEADBEEF, `respError`=0; `memWrite` high exactly cycles 2–3 after store acceptance.
- Store byte 0x80 at 0x21; load byte at 0x21 signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- Store halfword 0x8001 at 0x40; load signed half -> 0xFFFF8001; load unsigned byte at 0x41 -> 0x00000080.
- Word load at 0x13, half load at 0x05, size 3 at 0x00, word load at 0x1FE (memBytes=512) -> each `respError`=1, `respData`=0, `respValid` one cycle after acceptance, `memRead`/`memWrite` never high.
- Hold `reqValid` continuously with two stores -> second accepted exactly 5 cycles after first; `reqReady` low cycles 1–4.
- Assert `reset` during STROBE of a load -> `memRead` falls without a clock edge, no `respValid`, `reqReady`=1 after release, next request completes normally.
